filter_gather: RTL
==================

# filter_gather

Reassembles filter-serial convolution results into per-position feature columns. Upstream, each frame is replayed once per filter, so results arrive filter-major: NUM_FILTERS passes of FRAME_LEN scalars each. This block buffers one full frame and drains it position-major as FRAME_LEN columns, each NUM_FILTERS*BW wide, to the next layer. It is the inverse of the frame-recycling serializer upstream.

## Interface
- BW, 8, bits per signed result element
- FRAME_LEN, 50, positions per filter pass (output columns per frame)
- NUM_FILTERS, 8, number of filter passes per frame (elements per output column)
- clk_i  input  1  clock; all logic on rising edge
- rst_n_i  input  1  reset, asynchronous, active-low
- data_i  input  BW  signed result of current filter at current position
- valid_i  input  1  data_i valid
- last_i  input  1  marks final beat of frame (beat NUM_FILTERS*FRAME_LEN-1)
- ready_o  output  1  block accepts data_i this cycle
- data_o  output  NUM_FILTERS*BW  column; filter f at bits [f*BW +: BW], filter 0 in LSBs
- valid_o  output  1  data_o valid
- last_o  output  1  final column of frame (position FRAME_LEN-1)
- ready_i  input  1  downstream accepts data_o
- frame_err_o  output  1  one-cycle pulse on last_i/counter mismatch

## Operation
- Storage: FRAME_LEN x NUM_FILTERS x BW register array, single-buffered; not reset.
- Counters: pos_cnt ($clog2(FRAME_LEN) bits), filt_cnt ($clog2(NUM_FILTERS) bits), rd_cnt ($clog2(FRAME_LEN) bits). All reset to 0.
- State COLLECT:
  - ready_o=1 and valid_o=0.
  - On accept (valid_i & ready_o), write data_i to buf[pos_cnt][filt_cnt], then increment pos_cnt.
  - When pos_cnt wraps at FRAME_LEN-1, it returns to 0 and filt_cnt increments.
  - Accepting beat (pos=FRAME_LEN-1, filt=NUM_FILTERS-1): filt_cnt returns to 0, go to DRAIN.
- State DRAIN:
  - ready_o=0, valid_o=1, data_o=buf[rd_cnt], last_o=(rd_cnt==FRAME_LEN-1).
  - On valid_o & ready_i, rd_cnt increments.
  - On acceptance of the last_o column, rd_cnt returns to 0, go to COLLECT.
- Sequencing is counter-driven only. last_i never shortens or extends a frame.
- frame_err_o pulses on any accepted beat where last_i differs from "this is beat NUM_FILTERS*FRAME_LEN-1", i.e. early last_i or missing last_i.
- Gaps in valid_i are allowed anywhere mid-frame; counters hold while valid_i=0.
- data_o=0 and last_o=0 whenever valid_o=0.

## Timing
- Reset values: state=COLLECT, ready_o=1, valid_o=0, last_o=0, data_o=0, frame_err_o=0.
- Reset asserted mid-frame or mid-drain: collected data is discarded, counters clear, and the next accepted beat is pos 0 / filter 0.
- Latency: final input beat accepted at edge t. At t+1, valid_o=1 with column 0 and ready_o=0.
- Drain rate: one column per cycle when ready_i=1. The minimum drain is FRAME_LEN cycles.
- The last column is accepted at edge u. At u+1, ready_o=1 and valid_o=0. There is no overlap between collecting and draining, so throughput is one frame per NUM_FILTERS*FRAME_LEN + FRAME_LEN cycles minimum.
- Backpressure: while ready_i=0, data_o, valid_o and last_o hold stable.
- valid_i is ignored in DRAIN. The upstream must honour ready_o=0.
- frame_err_o is registered and asserts the cycle after the offending beat's accept edge.
- ready_o, valid_o and last_o are decoded from registered state and counters. There is no combinational path from ready_i or valid_i to any output.

## Test plan
- Reset state: hold rst_n_i=0, then release -> ready_o=1, valid_o=0, data_o=0, frame_err_o=0.
- Basic frame (BW=8, FRAME_LEN=4, NUM_FILTERS=2):
  - Stimulus: 8 beats with data = 16*f+p (values 0,1,2,3,16,17,18,19), last_i only on beat 7.
  - Required: columns 0x1000, 0x1101, 0x1202, 0x1303, with last_o only on 0x1303 and frame_err_o never pulsing.
  - Required: valid_o rises exactly 1 cycle after beat 7 is accepted.
- Backpressure: same frame, ready_i=0 for 3 cycles during column 1 -> 0x1101 held 3 cycles, no column skipped or duplicated, ready_o stays 0 until column 3 is accepted.
- Input gaps and signedness:
  - Stimulus: valid_i toggled randomly, data -128 and 127 mixed.
  - Required: columns match a golden transpose, e.g. filter1=-128 and filter0=127 gives 0x807F.
- Back-to-back frames: valid_i held high across the drain -> no beats accepted during DRAIN, and the second frame's columns are correct.
- Error and reset:
  - last_i asserted on beat 3 -> frame_err_o pulses once, and the frame still completes after 8 beats.
  - rst_n_i pulsed after beat 5 -> outputs return to reset values, and the next 8 beats form a clean frame.

Source files
------------

// File: rtl/filter_gather.sv
// Buffers one filter-major frame and drains it as position-major columns.
// Latency: first column is valid the cycle after the final input beat is accepted.
// Backpressure: no input is taken while draining; columns hold stable while ready_i=0.
module filter_gather #(
    parameter int BW          = 8,
    parameter int FRAME_LEN   = 50,
    parameter int NUM_FILTERS = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [BW-1:0]             data_i,
    input  logic                      valid_i,
    input  logic                      last_i,
    output logic                      ready_o,
    output logic [NUM_FILTERS*BW-1:0] data_o,
    output logic                      valid_o,
    output logic                      last_o,
    input  logic                      ready_i,
    output logic                      frame_err_o
);

    localparam int PW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam logic [PW-1:0] POS_LAST  = PW'(FRAME_LEN - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(NUM_FILTERS - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [PW-1:0] pos_cnt;
    logic [FW-1:0] filt_cnt;
    logic [PW-1:0] rd_cnt;
    logic          err_q;

    // One row per position; each row is already laid out as an output column.
    logic [NUM_FILTERS*BW-1:0] frame_mem [FRAME_LEN];

    logic in_acc;
    logic out_acc;
    logic pos_wrap;
    logic frame_end;
    logic rd_end;

    assign in_acc    = valid_i && (state_q == COLLECT);
    assign out_acc   = ready_i && (state_q == DRAIN);
    assign pos_wrap  = (pos_cnt == POS_LAST);
    assign frame_end = pos_wrap && (filt_cnt == FILT_LAST);
    assign rd_end    = (rd_cnt == POS_LAST);

    assign frame_err_o = err_q;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and outputs, decoded only from registered state and counters.
    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        last_o  = 1'b0;
        data_o  = '0;
        case (state_q)
            COLLECT: begin
                ready_o = 1'b1;
                if (in_acc && frame_end) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                valid_o = 1'b1;
                data_o  = frame_mem[rd_cnt];
                last_o  = rd_end;
                if (ready_i && rd_end) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Write/read position counters; the frame length is fixed by these alone, never by last_i.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pos_cnt  <= '0;
            filt_cnt <= '0;
            rd_cnt   <= '0;
        end else begin
            if (in_acc) begin
                if (pos_wrap) begin
                    pos_cnt  <= '0;
                    filt_cnt <= frame_end ? '0 : filt_cnt + 1'b1;
                end else begin
                    pos_cnt <= pos_cnt + 1'b1;
                end
            end
            if (out_acc) begin
                rd_cnt <= rd_end ? '0 : rd_cnt + 1'b1;
            end
        end
    end

    // Flag a beat whose last_i disagrees with the counter's notion of the frame end.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= in_acc && (last_i != frame_end);
        end
    end

    // Scatter each accepted scalar into its column slot; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (in_acc) begin
            frame_mem[pos_cnt][filt_cnt*BW +: BW] <= data_i;
        end
    end

endmodule
